// File: rtl/arm_multicycle_controller.sv
// Control unit for the multicycle ARM datapath: main sequencing FSM, ALU command
// decode, NZCV flag register and condition-code evaluation.
module arm_multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ALUControl,
    output logic [3:0]         Flags,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMRD    = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWR    = STATE_W'(5),
        S_EXECUTER = STATE_W'(6),
        S_EXECUTEI = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BRANCH   = STATE_W'(9)
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_flags;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_cmd;
    logic        w_rd15;
    logic        w_unused;

    logic [1:0]  w_alu_ctl;
    logic        w_cmd_ok;
    logic        w_cv_upd;
    logic        w_condex;
    logic        w_n, w_z, w_c, w_v;
    logic        w_exec;

    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_cmd    = w_funct[4:1];
    assign w_rd15   = (Instr[3:0] == 4'hF);
    assign w_unused = ^Instr[7:4];

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign w_exec = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);

    // Unrecognised commands still flow through ALUWB but never write the register file.
    always_comb begin
        w_alu_ctl = 2'b00;
        w_cmd_ok  = 1'b1;
        w_cv_upd  = 1'b0;
        case (w_cmd)
            4'b0100: begin w_alu_ctl = 2'b00; w_cv_upd = 1'b1; end
            4'b0010: begin w_alu_ctl = 2'b01; w_cv_upd = 1'b1; end
            4'b1010: begin w_alu_ctl = 2'b01; w_cv_upd = 1'b1; end
            4'b0000: w_alu_ctl = 2'b10;
            4'b1100: w_alu_ctl = 2'b11;
            default: w_cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'h0: w_condex = w_z;
            4'h1: w_condex = ~w_z;
            4'h2: w_condex = w_c;
            4'h3: w_condex = ~w_c;
            4'h4: w_condex = w_n;
            4'h5: w_condex = ~w_n;
            4'h6: w_condex = w_v;
            4'h7: w_condex = ~w_v;
            4'h8: w_condex = w_c & ~w_z;
            4'h9: w_condex = ~(w_c & ~w_z);
            4'hA: w_condex = (w_n == w_v);
            4'hB: w_condex = (w_n != w_v);
            4'hC: w_condex = ~w_z & (w_n == w_v);
            4'hD: w_condex = w_z | (w_n != w_v);
            4'hE: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // C/V only follow the ALU for arithmetic commands; logical ops leave them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (w_exec && w_funct[0]) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_cv_upd) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!w_condex)           w_next = S_FETCH;
                else if (w_op == 2'b01)  w_next = S_MEMADR;
                else if (w_op == 2'b00)  w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                else if (w_op == 2'b10)  w_next = S_BRANCH;
                else                     w_next = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                PCWrite   = w_rd15;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (r_state == S_EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = w_alu_ctl;
                w_next     = (w_cmd == 4'b1010) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = w_cmd_ok;
                PCWrite  = w_rd15;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign ImmSrc = w_op;
    assign RegSrc = {(w_op == 2'b01), (w_op == 2'b10)};
    assign Flags  = r_flags;
    assign State  = r_state;

endmodule
